// File: rtl/sigma_delta_adc.sv
// First-order sigma-delta ADC front end with an N-stage CIC decimator.
// Comparator bit in, feedback bit out, unsigned PCM samples with a valid strobe.
module sigma_delta_adc #(
    parameter int OVERSAMPLE_RATE = 256,
    parameter int CIC_STAGES      = 2,
    parameter int ADC_BITLEN      = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  adc_cmp,
    output logic                  adc_fb,
    output logic [ADC_BITLEN-1:0] adc_output,
    output logic                  adc_valid
);

    localparam int LR  = $clog2(OVERSAMPLE_RATE);
    localparam int W   = CIC_STAGES * LR;
    localparam int AW  = W + 1;
    localparam int WCW = $clog2(CIC_STAGES + 1);
    localparam logic [AW-1:0] FULL = {1'b1, {W{1'b0}}};

    if (OVERSAMPLE_RATE <= CIC_STAGES + 1 ||
        OVERSAMPLE_RATE < 4 || OVERSAMPLE_RATE > 1024 ||
        (OVERSAMPLE_RATE & (OVERSAMPLE_RATE - 1)) != 0 ||
        CIC_STAGES < 1 || CIC_STAGES > 5 ||
        ADC_BITLEN < 8 || ADC_BITLEN > 32) begin : g_bad_cfg
        $error("sigma_delta_adc: unsupported parameter set");
    end

    typedef enum logic {
        WARMUP,
        RUN
    } state_e;

    logic                  sync1_q;
    logic                  sync2_q;
    logic                  fb_q;
    logic [LR-1:0]         cnt_q;
    logic [LR-1:0]         cnt_d;
    logic                  strobe;
    logic [AW-1:0]         int_q [CIC_STAGES];
    logic [AW-1:0]         int_d [CIC_STAGES];
    logic [AW-1:0]         st_q  [CIC_STAGES];
    logic [AW-1:0]         dl_q  [CIC_STAGES];
    logic [CIC_STAGES-1:0] vld_q;
    logic [CIC_STAGES-1:0] pub_q;
    state_e                state_q;
    state_e                state_d;
    logic [WCW-1:0]        wcnt_q;
    logic [WCW-1:0]        wcnt_d;
    logic [AW-1:0]         y;
    logic [ADC_BITLEN-1:0] sc;
    logic [ADC_BITLEN-1:0] s;
    logic [ADC_BITLEN-1:0] out_q;
    logic                  valid_q;

    always_comb begin
        cnt_d    = cnt_q + LR'(1);
        strobe   = &cnt_q;
        int_d[0] = int_q[0] + AW'(fb_q);
        for (int k = 1; k < CIC_STAGES; k++) begin
            int_d[k] = int_q[k] + int_q[k-1];
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        unique case (state_q)
            WARMUP: begin
                if (strobe) begin
                    if (wcnt_q == WCW'(CIC_STAGES - 1)) begin
                        state_d = RUN;
                    end else begin
                        wcnt_d = wcnt_q + WCW'(1);
                    end
                end
            end
            RUN: state_d = RUN;
        endcase
    end

    // The last comb stage is folded into the scaling register.
    assign y = st_q[CIC_STAGES-1] - dl_q[CIC_STAGES-1];

    if (ADC_BITLEN <= W) begin : g_shr
        assign sc = y[W-1 -: ADC_BITLEN];
    end else begin : g_shl
        assign sc = {y[W-1:0], {(ADC_BITLEN - W){1'b0}}};
    end

    assign s = (y == FULL) ? '1 : sc;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fb_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= WARMUP;
            wcnt_q  <= '0;
            vld_q   <= '0;
            pub_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            for (int k = 0; k < CIC_STAGES; k++) begin
                int_q[k] <= '0;
                st_q[k]  <= '0;
                dl_q[k]  <= '0;
            end
        end else begin
            sync1_q <= adc_cmp;
            sync2_q <= sync1_q;
            fb_q    <= sync2_q;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            for (int k = 0; k < CIC_STAGES; k++) begin
                int_q[k] <= int_d[k];
            end
            // Publish flag travels with its sample so warm-up strobes are dropped.
            vld_q[0] <= strobe;
            pub_q[0] <= strobe && (state_q == RUN);
            if (strobe) begin
                st_q[0] <= int_q[CIC_STAGES-1];
            end
            for (int k = 1; k < CIC_STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                pub_q[k] <= pub_q[k-1];
                if (vld_q[k-1]) begin
                    st_q[k]   <= st_q[k-1] - dl_q[k-1];
                    dl_q[k-1] <= st_q[k-1];
                end
            end
            if (vld_q[CIC_STAGES-1]) begin
                dl_q[CIC_STAGES-1] <= st_q[CIC_STAGES-1];
            end
            valid_q <= pub_q[CIC_STAGES-1];
            if (pub_q[CIC_STAGES-1]) begin
                out_q <= s;
            end
        end
    end

    assign adc_fb     = fb_q;
    assign adc_output = out_q;
    assign adc_valid  = valid_q;

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Bench for sigma_delta_adc: FIR-kernel reference model, pattern table,
// latency and mid-run reset sequences, plus a wide-config instance.
module tb_sigma_delta_adc;

    localparam int R    = 64;
    localparam int N    = 2;
    localparam int BL   = 16;
    localparam int W    = N * 6;
    localparam int HL   = N * (R - 1) + 1;
    localparam int MAXC = 16384;
    localparam int RB   = 256;
    localparam int BLB  = 24;

    typedef struct {
        int          mode;
        int          ncyc;
        bit          chk;
        logic [15:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          adc_cmp = 1'b0;
    logic          adc_fb;
    logic [BL-1:0] adc_output;
    logic          adc_valid;
    logic           cmp_b = 1'b0;
    logic           fb_b;
    logic [BLB-1:0] out_b;
    logic           valid_b;

    int          vecs = 0;
    int          errs = 0;
    int          cyc = 0;
    int          last_v = -1;
    int          nb = 0;
    int          fc = 0;
    logic [BL-1:0] exp_out = '0;
    logic [BL-1:0] tbl_exp = '0;
    bit          tbl_on = 1'b0;
    bit          cmp_h [MAXC];
    int          h [HL];

    always #5 clk = ~clk;

    sigma_delta_adc #(
        .OVERSAMPLE_RATE(R), .CIC_STAGES(N), .ADC_BITLEN(BL)
    ) u_dut (
        .clk(clk), .rst(rst), .adc_cmp(adc_cmp), .adc_fb(adc_fb),
        .adc_output(adc_output), .adc_valid(adc_valid)
    );

    sigma_delta_adc #(
        .OVERSAMPLE_RATE(RB), .CIC_STAGES(2), .ADC_BITLEN(BLB)
    ) u_big (
        .clk(clk), .rst(rst), .adc_cmp(cmp_b), .adc_fb(fb_b),
        .adc_output(out_b), .adc_valid(valid_b)
    );

    task automatic check(string name, longint act, longint req);
        vecs++;
        if (act != req) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %0h, required %0h",
                     name, cyc, act, req);
        end
    endtask

    // y for the strobe in cycle t: CIC kernel applied to the fb stream,
    // where fb in cycle i is the comparator value of cycle i-3.
    function automatic int yref(int t);
        int acc = 0;
        for (int j = 0; j < HL; j++) begin
            int i = t - N - j - 3;
            if (i >= 0) acc += h[j] * int'(cmp_h[i]);
        end
        return acc;
    endfunction

    function automatic logic [BL-1:0] scale(int y);
        if (y == R ** N) return '1;
        return BL'(y * (1 << (BL - W)));
    endfunction

    function automatic bit pat(int mode, int i);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return (i % 2) == 0;
            3: return (i % 4) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            cyc = 0;
            last_v = -1;
            exp_out = '0;
        end else begin
            if (cyc < MAXC) begin
                cmp_h[cyc] = adc_cmp;
                check("fb", adc_fb, (cyc >= 3) ? cmp_h[cyc-3] : 1'b0);
                if (cyc >= (N + 1) * R + N && (cyc - N) % R == 0) begin
                    exp_out = scale(yref(cyc - N - 1));
                    check("valid", adc_valid, 1);
                    check("sample", adc_output, exp_out);
                    if (tbl_on) check("table", adc_output, tbl_exp);
                    if (last_v >= 0) check("spacing", cyc - last_v, R);
                    last_v = cyc;
                end else begin
                    check("novalid", adc_valid, 0);
                    check("hold", adc_output, exp_out);
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst && valid_b) begin
            nb++;
            check("big", out_b, 24'h400000);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cmp_b = (fc % 4) == 0;
            fc++;
        end
    end

    task automatic do_reset(int k);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (k) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic measure(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!adc_valid && n < 400);
    endtask

    initial begin
        vec_t tbl [5];
        int   tmp [HL];
        int   n;

        for (int j = 0; j < HL; j++) h[j] = (j == 0) ? 1 : 0;
        for (int s = 0; s < N; s++) begin
            for (int j = 0; j < HL; j++) begin
                tmp[j] = 0;
                for (int k = 0; k < R; k++)
                    if (j - k >= 0) tmp[j] += h[j-k];
            end
            h = tmp;
        end

        tbl[0] = '{mode: 0, ncyc: 600,  chk: 1'b1, exp: 16'h0000};
        tbl[1] = '{mode: 1, ncyc: 9000, chk: 1'b1, exp: 16'hFFFF};
        tbl[2] = '{mode: 2, ncyc: 600,  chk: 1'b1, exp: 16'h8000};
        tbl[3] = '{mode: 3, ncyc: 600,  chk: 1'b1, exp: 16'h4000};
        tbl[4] = '{mode: 4, ncyc: 9000, chk: 1'b0, exp: 16'h0000};

        repeat (3) @(posedge clk);
        for (int v = 0; v < 5; v++) begin
            tbl_on = 1'b0;
            do_reset(2);
            tbl_exp = tbl[v].exp;
            tbl_on = tbl[v].chk;
            for (int c = 0; c < tbl[v].ncyc; c++) begin
                @(posedge clk);
                #1 adc_cmp = pat(tbl[v].mode, c);
            end
        end

        tbl_on = 1'b1;
        tbl_exp = 16'hFFFF;
        adc_cmp = 1'b1;
        do_reset(1);
        measure(n);
        check("latency", n, 3 * R - 1 + N + 1);
        // Land one cycle past the strobe so a sample is in flight.
        repeat (126) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out", adc_output, 0);
        check("rst_valid", adc_valid, 0);
        check("rst_fb", adc_fb, 0);
        measure(n);
        check("latency2", n, 3 * R - 1 + N + 1);
        repeat (600) @(posedge clk);
        check("big_seen", nb > 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
